// File: rtl/cpu_muldiv_sequencer_pkg.sv
// cpu_muldiv_sequencer_pkg: shared op encodings, FSM states and default
// latencies for the multiply/divide sequencer.
package cpu_muldiv_sequencer_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_WAIT,
        ST_DIV_WAIT,
        ST_DONE
    } md_state_e;

    localparam int unsigned DEFAULT_MUL_LATENCY = 2;
    localparam int unsigned DEFAULT_DIV_LATENCY = 33;

    // Wide enough for the largest divider latency (63)
    localparam int unsigned MD_CNT_W = 6;

    // Operand signedness for the multiplier: [1] = op1 signed, [0] = op2 signed
    function automatic logic [1:0] mul_signedness(input md_op_e op);
        case (op)
            MD_MULH:   return 2'b11;
            MD_MULHSU: return 2'b10;
            default:   return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/cpu_muldiv_sequencer_fixup.sv
// cpu_muldiv_sequencer_fixup: combinational detection of the RISC-V divide
// corner cases (divide by zero, signed overflow) and their fixed results.
module cpu_muldiv_sequencer_fixup (
    input  logic [2:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        hit,
    output logic [31:0] result
);

    logic div_by_zero;
    logic overflow;

    // op[2] marks divide-class, op[1] marks remainder, op[0] marks unsigned
    always_comb begin
        div_by_zero = (rs2 == '0);
        overflow    = !op[0] && (rs1 == 32'h8000_0000) && (rs2 == '1);
        hit         = op[2] && (div_by_zero || overflow);
        result      = '0;
        if (div_by_zero) begin
            result = op[1] ? rs1 : '1;
        end else if (overflow) begin
            result = op[1] ? '0 : 32'h8000_0000;
        end
    end

endmodule

// File: rtl/cpu_muldiv_sequencer.sv
// cpu_muldiv_sequencer: sequences the shared pipelined multiplier and
// iterative divider for the execute stage, one operation at a time.
// Optional feature macro: CPU_MULDIV_REUSE_EN (reuse of the last divide result).
module cpu_muldiv_sequencer
    import cpu_muldiv_sequencer_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = DEFAULT_MUL_LATENCY,
    parameter int unsigned DIV_LATENCY = DEFAULT_DIV_LATENCY,
    parameter int unsigned TAG_SIZE    = 4
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic                i_request,
    input  logic                i_flush,
    input  logic [TAG_SIZE-1:0] i_tag,
    input  logic [2:0]          i_op,
    input  logic [31:0]         i_rs1,
    input  logic [31:0]         i_rs2,
    output logic                o_ready,
    output logic                o_valid,
    output logic [TAG_SIZE-1:0] o_tag,
    output logic [31:0]         o_result,
    output logic [1:0]          o_mul_signed,
    output logic [31:0]         o_mul_op1,
    output logic [31:0]         o_mul_op2,
    input  logic [63:0]         i_mul_result,
    output logic                o_div_signed,
    output logic [31:0]         o_div_num,
    output logic [31:0]         o_div_den,
    input  logic [31:0]         i_div_quot,
    input  logic [31:0]         i_div_rem
);

    localparam logic [MD_CNT_W-1:0] MUL_LOAD = MD_CNT_W'(MUL_LATENCY - 1);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD = MD_CNT_W'(DIV_LATENCY - 1);
    localparam logic [MD_CNT_W-1:0] CNT_ONE  = MD_CNT_W'(1);

    md_state_e           state;
    md_op_e              op_q;
    md_op_e              req_op;
    logic [MD_CNT_W-1:0] count;

    logic        fix_hit;
    logic [31:0] fix_result;
    logic        reuse_hit;
    logic [31:0] reuse_result;

    assign req_op = md_op_e'(i_op);

    cpu_muldiv_sequencer_fixup u_fixup (
        .op     (i_op),
        .rs1    (i_rs1),
        .rs2    (i_rs2),
        .hit    (fix_hit),
        .result (fix_result)
    );

`ifdef CPU_MULDIV_REUSE_EN
    logic        cache_valid;
    logic        cache_signed;
    logic [31:0] cache_num;
    logic [31:0] cache_den;
    logic [31:0] cache_quot;
    logic [31:0] cache_rem;

    // Remember the last completed divide; any flush drops it
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cache_valid  <= 1'b0;
            cache_signed <= 1'b0;
            cache_num    <= '0;
            cache_den    <= '0;
            cache_quot   <= '0;
            cache_rem    <= '0;
        end else if (i_flush) begin
            cache_valid <= 1'b0;
        end else if (state == ST_DIV_WAIT && count == '0) begin
            cache_valid  <= 1'b1;
            cache_signed <= o_div_signed;
            cache_num    <= o_div_num;
            cache_den    <= o_div_den;
            cache_quot   <= i_div_quot;
            cache_rem    <= i_div_rem;
        end
    end

    // DIV and REM (or DIVU and REMU) share one cached divider run
    assign reuse_hit    = i_op[2] && cache_valid && (cache_signed == !i_op[0]) &&
                          (cache_num == i_rs1) && (cache_den == i_rs2);
    assign reuse_result = i_op[1] ? cache_rem : cache_quot;
`else
    assign reuse_hit    = 1'b0;
    assign reuse_result = '0;
`endif

    // Sequencer FSM: accept, count out the unit latency, pulse the result
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= ST_IDLE;
            op_q         <= MD_MUL;
            count        <= '0;
            o_ready      <= 1'b0;
            o_valid      <= 1'b0;
            o_tag        <= '0;
            o_result     <= '0;
            o_mul_signed <= '0;
            o_mul_op1    <= '0;
            o_mul_op2    <= '0;
            o_div_signed <= 1'b0;
            o_div_num    <= '0;
            o_div_den    <= '0;
        end else begin
            o_valid <= 1'b0;
            if (i_flush) begin
                state   <= ST_IDLE;
                o_ready <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        o_ready <= 1'b1;
                        if (i_request && o_ready) begin
                            o_ready <= 1'b0;
                            o_tag   <= i_tag;
                            op_q    <= req_op;
                            if (!i_op[2]) begin
                                o_mul_signed <= mul_signedness(req_op);
                                o_mul_op1    <= i_rs1;
                                o_mul_op2    <= i_rs2;
                                count        <= MUL_LOAD;
                                state        <= ST_MUL_WAIT;
                            end else if (fix_hit) begin
                                o_result <= fix_result;
                                o_valid  <= 1'b1;
                                state    <= ST_DONE;
                            end else if (reuse_hit) begin
                                o_result <= reuse_result;
                                o_valid  <= 1'b1;
                                state    <= ST_DONE;
                            end else begin
                                o_div_signed <= !i_op[0];
                                o_div_num    <= i_rs1;
                                o_div_den    <= i_rs2;
                                count        <= DIV_LOAD;
                                state        <= ST_DIV_WAIT;
                            end
                        end
                    end
                    ST_MUL_WAIT: begin
                        if (count == '0) begin
                            o_result <= (op_q == MD_MUL) ? i_mul_result[31:0] : i_mul_result[63:32];
                            o_valid  <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            count <= count - CNT_ONE;
                        end
                    end
                    ST_DIV_WAIT: begin
                        if (count == '0) begin
                            o_result <= (op_q == MD_REM || op_q == MD_REMU) ? i_div_rem : i_div_quot;
                            o_valid  <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            count <= count - CNT_ONE;
                        end
                    end
                    ST_DONE: begin
                        state   <= ST_IDLE;
                        o_ready <= 1'b1;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        o_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
